// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: EX-stage destination select, load-use stall sequencing,
// EX/MEM/WB destination shadows and ALU operand forwarding selects.
module ex_hazard_ctrl #(
   parameter int REG_W      = 5,
   parameter int LOAD_STALL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             id_regdst,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             flush,
   output logic             stall,
   output logic             ex_regdst_sel,
   output logic [REG_W-1:0] ex_dest,
   output logic [REG_W-1:0] mem_dest,
   output logic [REG_W-1:0] wb_dest,
   output logic             wb_regwrite,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b
);

   typedef enum logic {IDLE, STALL} state_t;

   state_t           state;
   logic [2:0]       cnt;
   logic [REG_W-1:0] ex_rs;
   logic [REG_W-1:0] ex_rt;
   logic             ex_regwrite;
   logic             ex_memread;
   logic             mem_regwrite;
   logic             load_use;
   logic             bubble;

   assign load_use = ex_memread & (ex_dest != '0) & id_valid &
                     ((ex_dest == id_rs) | (ex_dest == id_rt));

   // Gated by rst so a reset mid-stall releases the front end at once.
   assign stall  = ~rst & (((state == IDLE) & load_use & ~flush) |
                           (state == STALL));
   assign bubble = stall | flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (flush) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (load_use && LOAD_STALL > 1) begin
                  state <= STALL;
                  cnt   <= 3'(LOAD_STALL - 1);
               end
            end
            STALL: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1)
                  state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_rs         <= '0;
         ex_rt         <= '0;
         ex_dest       <= '0;
         ex_regdst_sel <= 1'b0;
         ex_regwrite   <= 1'b0;
         ex_memread    <= 1'b0;
      end else if (bubble) begin
         ex_rs         <= '0;
         ex_rt         <= '0;
         ex_dest       <= '0;
         ex_regdst_sel <= 1'b0;
         ex_regwrite   <= 1'b0;
         ex_memread    <= 1'b0;
      end else begin
         ex_rs         <= id_rs;
         ex_rt         <= id_rt;
         ex_dest       <= id_regdst ? id_rd : id_rt;
         ex_regdst_sel <= id_regdst;
         ex_regwrite   <= id_regwrite & id_valid;
         ex_memread    <= id_memread & id_valid;
      end
   end

   // Downstream shadows keep moving while the front end is frozen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_dest     <= '0;
         mem_regwrite <= 1'b0;
         wb_dest      <= '0;
         wb_regwrite  <= 1'b0;
      end else begin
         mem_dest     <= ex_dest;
         mem_regwrite <= ex_regwrite;
         wb_dest      <= mem_dest;
         wb_regwrite  <= mem_regwrite;
      end
   end

   function automatic logic [1:0] fwd_sel(
      input logic [REG_W-1:0] src,
      input logic [REG_W-1:0] mdst,
      input logic             mwr,
      input logic [REG_W-1:0] wdst,
      input logic             wwr
   );
      if (mwr && mdst != '0 && mdst == src)
         return 2'b10;
      if (wwr && wdst != '0 && wdst == src)
         return 2'b01;
      return 2'b00;
   endfunction

   assign fwd_a = fwd_sel(ex_rs, mem_dest, mem_regwrite,
                          wb_dest, wb_regwrite);
   assign fwd_b = fwd_sel(ex_rt, mem_dest, mem_regwrite,
                          wb_dest, wb_regwrite);

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: three DUTs (LOAD_STALL 1..3) share one stimulus stream;
// an instruction-level pipeline model feeds a scoreboard checked each cycle.
module tb_ex_hazard_ctrl;

   localparam int N = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       v, dst, rw, mr, fl;
   logic [4:0] rs, rt, rd;

   logic       stall_o [N];
   logic       sel_o   [N];
   logic [4:0] exd_o   [N];
   logic [4:0] memd_o  [N];
   logic [4:0] wbd_o   [N];
   logic       wbrw_o  [N];
   logic [1:0] fa_o    [N];
   logic [1:0] fb_o    [N];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      ex_hazard_ctrl #(.REG_W(5), .LOAD_STALL(g + 1)) dut (
         .clk          (clk),
         .rst          (rst),
         .id_valid     (v),
         .id_rs        (rs),
         .id_rt        (rt),
         .id_rd        (rd),
         .id_regdst    (dst),
         .id_regwrite  (rw),
         .id_memread   (mr),
         .flush        (fl),
         .stall        (stall_o[g]),
         .ex_regdst_sel(sel_o[g]),
         .ex_dest      (exd_o[g]),
         .mem_dest     (memd_o[g]),
         .wb_dest      (wbd_o[g]),
         .wb_regwrite  (wbrw_o[g]),
         .fwd_a        (fa_o[g]),
         .fwd_b        (fb_o[g])
      );
   end

   // One in-flight instruction as seen by the hazard unit.
   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dest;
      logic       wr;
      logic       ld;
      logic       sel;
   } ins_t;

   typedef struct packed {
      logic       stall;
      logic       sel;
      logic [4:0] exd;
      logic [4:0] memd;
      logic [4:0] wbd;
      logic       wbrw;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   typedef exp_t [N-1:0] exp3_t;

   ins_t  ex_m [N];
   ins_t  mem_m[N];
   ins_t  wb_m [N];
   int    left [N];
   exp3_t q[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   function automatic void model_reset();
      for (int k = 0; k < N; k++) begin
         ex_m[k]  = '0;
         mem_m[k] = '0;
         wb_m[k]  = '0;
         left[k]  = 0;
      end
   endfunction

   function automatic bit hazard(int k);
      return ex_m[k].ld && ex_m[k].dest != 0 && v &&
             (ex_m[k].dest == rs || ex_m[k].dest == rt);
   endfunction

   function automatic bit want_stall(int k);
      if (rst) return 1'b0;
      if (left[k] > 0) return 1'b1;
      return hazard(k) && !fl;
   endfunction

   // Youngest in-flight writer of r wins; $0 is never forwarded.
   function automatic logic [1:0] src_of(int k, logic [4:0] r);
      if (r == 0) return 2'b00;
      if (mem_m[k].wr && mem_m[k].dest == r) return 2'b10;
      if (wb_m[k].wr && wb_m[k].dest == r) return 2'b01;
      return 2'b00;
   endfunction

   function automatic exp_t expect_k(int k);
      exp_t e;
      e.stall = want_stall(k);
      e.sel   = ex_m[k].sel;
      e.exd   = ex_m[k].dest;
      e.memd  = mem_m[k].dest;
      e.wbd   = wb_m[k].dest;
      e.wbrw  = wb_m[k].wr;
      e.fa    = src_of(k, ex_m[k].rs);
      e.fb    = src_of(k, ex_m[k].rt);
      return e;
   endfunction

   function automatic void advance();
      for (int k = 0; k < N; k++) begin
         bit st;
         st       = want_stall(k);
         wb_m[k]  = mem_m[k];
         mem_m[k] = ex_m[k];
         if (fl) begin
            ex_m[k] = '0;
            left[k] = 0;
         end else if (st) begin
            ex_m[k] = '0;
            left[k] = (left[k] > 0) ? left[k] - 1 : k;
         end else begin
            ex_m[k].rs   = rs;
            ex_m[k].rt   = rt;
            ex_m[k].dest = dst ? rd : rt;
            ex_m[k].wr   = rw & v;
            ex_m[k].ld   = mr & v;
            ex_m[k].sel  = dst;
         end
      end
   endfunction

   task automatic drive(input logic r, input logic iv,
                        input logic [4:0] irs, input logic [4:0] irt,
                        input logic [4:0] ird, input logic idst,
                        input logic irw, input logic imr, input logic ifl);
      exp3_t e;
      rst = r; v = iv; rs = irs; rt = irt; rd = ird;
      dst = idst; rw = irw; mr = imr; fl = ifl;
      if (rst) model_reset();
      for (int k = 0; k < N; k++) e[k] = expect_k(k);
      q.push_back(e);
      @(posedge clk);
      if (rst) model_reset();
      else advance();
      #1;
   endtask

   task automatic chk(input string nm, input int k,
                      input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s LS=%0d cyc %0d: got %0h want %0h",
                  nm, k + 1, cyc, act, exp);
      end
   endtask

   // Monitor: every cycle the DUTs present a full output set.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (q.size() > 0) begin
            exp3_t e;
            e = q.pop_front();
            for (int k = 0; k < N; k++) begin
               chk("stall", k, stall_o[k], e[k].stall);
               chk("regdst_sel", k, sel_o[k], e[k].sel);
               chk("ex_dest", k, exd_o[k], e[k].exd);
               chk("mem_dest", k, memd_o[k], e[k].memd);
               chk("wb_dest", k, wbd_o[k], e[k].wbd);
               chk("wb_regwrite", k, wbrw_o[k], e[k].wbrw);
               chk("fwd_a", k, fa_o[k], e[k].fa);
               chk("fwd_b", k, fb_o[k], e[k].fb);
            end
         end
      end
   end

   task automatic nop(input int n);
      for (int i = 0; i < n; i++)
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; v = 0; rs = 0; rt = 0; rd = 0;
      dst = 0; rw = 0; mr = 0; fl = 0;
      model_reset();
      @(posedge clk);
      #1;
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      // destination mux both ways
      drive(0, 1, 1, 5, 9, 1, 1, 0, 0);
      drive(0, 1, 1, 5, 9, 0, 1, 0, 0);
      nop(3);
      // load to $8 then a consumer held in ID while stalled
      drive(0, 1, 1, 8, 0, 0, 1, 1, 0);
      for (int i = 0; i < 4; i++)
         drive(0, 1, 8, 2, 3, 1, 1, 0, 0);
      nop(3);
      // MEM and WB both write $4; then WB-only match on rt
      drive(0, 1, 1, 2, 4, 1, 1, 0, 0);
      drive(0, 1, 1, 2, 4, 1, 1, 0, 0);
      drive(0, 1, 4, 2, 6, 1, 0, 0, 0);
      drive(0, 1, 1, 4, 7, 1, 1, 0, 0);
      nop(3);
      // load to $0 never stalls; write to $0 never forwards
      drive(0, 1, 1, 0, 0, 0, 1, 1, 0);
      drive(0, 1, 0, 0, 0, 0, 1, 0, 0);
      drive(0, 1, 0, 3, 0, 1, 1, 0, 0);
      nop(3);
      // load-use coinciding with flush
      drive(0, 1, 1, 8, 0, 0, 1, 1, 0);
      drive(0, 1, 8, 2, 3, 1, 1, 0, 1);
      drive(0, 1, 8, 2, 3, 1, 1, 0, 0);
      nop(3);
      // flush one cycle into the stall
      drive(0, 1, 1, 8, 0, 0, 1, 1, 0);
      drive(0, 1, 8, 2, 3, 1, 1, 0, 0);
      drive(0, 1, 8, 2, 3, 1, 1, 0, 1);
      drive(0, 1, 8, 2, 3, 1, 1, 0, 0);
      nop(3);
      // reset while stalled
      drive(0, 1, 1, 8, 0, 0, 1, 1, 0);
      drive(0, 1, 8, 2, 3, 1, 1, 0, 0);
      drive(1, 1, 8, 2, 3, 1, 1, 0, 0);
      drive(0, 1, 8, 2, 3, 1, 1, 0, 0);
      nop(3);
      for (int i = 0; i < 500; i++) begin
         drive(0,
               $urandom_range(0, 9) != 0,
               5'($urandom_range(0, 5)),
               5'($urandom_range(0, 5)),
               5'($urandom_range(0, 5)),
               1'($urandom_range(0, 1)),
               $urandom_range(0, 9) < 7,
               $urandom_range(0, 9) < 4,
               $urandom_range(0, 19) == 0);
      end
      nop(2);
      @(negedge clk);
      #1;
      chk("scoreboard_drained", 0, q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
